// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: word type, packed address view
// for the default 16-frame geometry, and the frame record returned by the array.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int IIDX_W = 4;
  localparam int ITAG_W = 26;
  // Frame tag field is wide enough for the smallest legal geometry (2 frames);
  // narrower tags are zero-extended into it.
  localparam int FTAG_W = 30;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  typedef struct packed {
    logic              valid;
    logic [FTAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

endpackage

// File: rtl/icache_if.sv
// Datapath-side and memory-side signal bundle of the instruction cache.
interface icache_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  word_t hit_count;
  word_t miss_count;

  modport cache (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport env (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

endinterface

// File: rtl/icache_array.sv
// Direct-mapped frame storage: combinational read port, one write port.
// Only the valid bits are reset; tag and data come up undefined.
module icache_array
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16,
  localparam int IDX_W = $clog2(NSETS),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] rd_idx,
  output icache_frame_t    rd_frame,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  word_t            wr_data
);

  logic [NSETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [NSETS];
  word_t            data_q [NSETS];

  // Valid bits: cleared asynchronously, set on refill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) valid_q <= '0;
    else if (wr_en) valid_q[wr_idx] <= 1'b1;
  end

  // Tag and data storage, written only on refill.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  // Read port: frame selected by the current fetch index.
  always_comb begin
    rd_frame.valid = valid_q[rd_idx];
    rd_frame.tag   = FTAG_W'(tag_q[rd_idx]);
    rd_frame.data  = data_q[rd_idx];
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with a blocking single-word refill.
//   state | meaning
//   IDLE  | look up fetch address; hit returns data, miss latches fill address
//   FILL  | read request to memory held until iwait drops, then frame written
module icache
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);

  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_e;

  state_e        state_q, state_d;
  word_t         fill_addr_q, fill_addr_d;
  word_t         hit_cnt_q, miss_cnt_q;
  logic          wr_en;
  logic          tag_match;
  icache_frame_t rd_frame;

  icache_array #(.NSETS(NSETS)) u_array (
    .CLK      (CLK),
    .nRST     (nRST),
    .rd_idx   (imemaddr[IDX_W+1:2]),
    .rd_frame (rd_frame),
    .wr_idx   (fill_addr_q[IDX_W+1:2]),
    .wr_en    (wr_en),
    .wr_tag   (fill_addr_q[31:IDX_W+2]),
    .wr_data  (iload)
  );

  assign tag_match = rd_frame.valid && (rd_frame.tag == FTAG_W'(imemaddr[31:IDX_W+2]));

  // State, fill address and event counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      if (ihit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if ((state_q == IDLE) && (state_d == FILL) && (miss_cnt_q != '1))
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  // Next state, lookup response and memory request.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    wr_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (imemREN) begin
          if (tag_match) begin
            ihit     = 1'b1;
            imemload = rd_frame.data;
          end else begin
            fill_addr_d = imemaddr & ~32'h3;
            state_d     = FILL;
          end
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = fill_addr_q;
        if (!iwait) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache with a queue scoreboard and an abstract cache model.
module tb_icache;
  import cpu_types_pkg::*;

  localparam int NS = 16;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  icache_if bus();

  icache #(.NSETS(NS)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (bus.imemREN),
    .imemaddr   (bus.imemaddr),
    .ihit       (bus.ihit),
    .imemload   (bus.imemload),
    .iREN       (bus.iREN),
    .iaddr      (bus.iaddr),
    .iwait      (bus.iwait),
    .iload      (bus.iload),
    .hit_count  (bus.hit_count),
    .miss_count (bus.miss_count)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] faddr;
    int          lat;
    int          start;
    bit          hit;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          done = 0;
  bit          mon_en = 1;

  // Abstract model: what each frame currently holds, plus expected counters.
  bit          m_valid [NS];
  logic [31:0] m_tag   [NS];
  logic [31:0] m_data  [NS];
  logic [31:0] m_hits, m_misses;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2001_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) m_valid[i] = 0;
    m_hits   = 0;
    m_misses = 0;
    sbq.delete();
  endtask

  // Monitor: checks every cycle; pops the scoreboard whenever the DUT reports a hit.
  always @(negedge CLK) begin
    if (mon_en && nRST) begin
      if (bus.ihit) begin
        if (sbq.size() == 0) begin
          check32("unexpected_ihit", {31'b0, bus.ihit}, 32'h0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check32("imemload", bus.imemload, e.data);
          check32("latency", 32'(cyc - e.start), 32'(e.lat));
          done = 1;
        end
      end else begin
        check32("imemload_nohit", bus.imemload, 32'h0);
      end
      if (bus.iREN) begin
        if (sbq.size() > 0 && !sbq[0].hit)
          check32("iaddr_fill", bus.iaddr, sbq[0].faddr);
        else
          check32("iREN_no_fill", {31'b0, bus.iREN}, 32'h0);
      end else begin
        check32("iaddr_idle", bus.iaddr, 32'h0);
      end
    end
  end

  task automatic check_counters(input string tag);
    check32({tag, "_hit_count"}, bus.hit_count, m_hits);
    check32({tag, "_miss_count"}, bus.miss_count, m_misses);
  endtask

  task automatic do_reset();
    nRST         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.iwait    = 1'b0;
    bus.iload    = '0;
    #1;
    check32("rst_ihit", {31'b0, bus.ihit}, 32'h0);
    check32("rst_iREN", {31'b0, bus.iREN}, 32'h0);
    check32("rst_iaddr", bus.iaddr, 32'h0);
    check32("rst_imemload", bus.imemload, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    model_clear();
    check_counters("rst");
  endtask

  // One fetch; caller is positioned just after a rising edge.
  task automatic do_req(input logic [31:0] a, input int nw,
                        input bit force_alt, input logic [31:0] alt);
    exp_t e;
    int   idx;
    logic [31:0] tg;
    idx     = int'((a >> 2) % NS);
    tg      = a >> 6;
    e.faddr = a & ~32'h3;
    e.hit   = m_valid[idx] && (m_tag[idx] == tg);
    e.lat   = e.hit ? 0 : 2 + nw;
    e.start = cyc;
    if (e.hit) begin
      e.data = m_data[idx];
    end else begin
      e.data       = mem_word(e.faddr);
      m_valid[idx] = 1;
      m_tag[idx]   = tg;
      m_data[idx]  = e.data;
      m_misses++;
    end
    m_hits++;
    done = 0;
    sbq.push_back(e);
    for (int k = 0; k < e.lat + 8; k++) begin
      if (k == 0 || k >= e.lat) begin
        bus.imemREN  = 1'b1;
        bus.imemaddr = a;
      end else if (force_alt) begin
        bus.imemREN  = 1'b1;
        bus.imemaddr = alt;
      end else begin
        bus.imemREN  = 1'($urandom_range(0, 1));
        bus.imemaddr = $urandom;
      end
      bus.iwait = e.hit ? 1'($urandom_range(0, 1)) : ((k >= 1) && (k <= nw));
      bus.iload = mem_word(bus.iaddr);
      @(posedge CLK);
      #1;
      if (done) break;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout: addr %h got no ihit expected one within %0d cycles", a, e.lat + 8);
      sbq.delete();
    end
    bus.imemREN = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.imemREN  = 1'b0;
      bus.imemaddr = $urandom;
      bus.iwait    = 1'($urandom_range(0, 1));
      bus.iload    = $urandom;
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    do_reset();

    // Cold miss, single FILL cycle.
    do_req(32'h0000_0040, 0, 0, 0);
    check_counters("cold");

    // Memory wait of four cycles, then conflict eviction.
    do_reset();
    do_req(32'h0000_0040, 4, 0, 0);
    do_req(32'h0000_0080, 0, 0, 0);
    do_req(32'h0000_0040, 0, 0, 0);
    check_counters("conflict");

    // Fetch address moves during FILL; then byte-offset alias hit.
    do_reset();
    do_req(32'h0000_0040, 2, 1, 32'h0000_0044);
    do_req(32'h0000_0044, 0, 0, 0);
    do_req(32'h0000_0043, 0, 0, 0);
    check_counters("redirect");

    // Reset asserted while a fill is outstanding.
    do_reset();
    mon_en       = 0;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0040;
    bus.iwait    = 1'b1;
    @(posedge CLK);
    #1;
    check32("midfill_iREN_before", {31'b0, bus.iREN}, 32'h1);
    bus.iwait = 1'b0;
    bus.iload = 32'hDEAD_BEEF;
    nRST      = 1'b0;
    #1;
    check32("midfill_iREN_rst", {31'b0, bus.iREN}, 32'h0);
    check32("midfill_iaddr_rst", bus.iaddr, 32'h0);
    @(posedge CLK);
    #1;
    nRST        = 1'b1;
    bus.imemREN = 1'b0;
    model_clear();
    check_counters("midfill");
    mon_en = 1;
    do_req(32'h0000_0040, 0, 0, 0);
    check_counters("after_midfill");

    // Randomized traffic over a small address pool to mix hits and conflicts.
    for (int n = 0; n < 250; n++) begin
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, NS - 1) << 2) | $urandom_range(0, 3);
      do_req(a, $urandom_range(0, 3), 0, 0);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      if (n % 50 == 49) check_counters("random");
    end
    check_counters("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
